uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises 8-bit bytes onto the board TX line at 8N1, or 8E1 when parity is compiled in. It is the upstream counterpart of `uart_rx` and sits between the byte-producing logic (a command responder or loopback echo) and the FPGA TX pin. Input uses a valid/ready handshake. The bit period is a fixed count of `clk` cycles: 434 for 50 MHz / 115200 baud.

## Interface
- `CLKS_PER_BIT`, 434, `clk` cycles per serial bit; legal range 2..65535.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled only on the accept cycle.
- `tx_valid`  input  1  producer has a byte on `tx_data`.
- `tx_ready`  output  1  registered; high only in IDLE.
- `tx_serial`  output  1  serial line; idle level is 1.
- `tx_busy`  output  1  high from the accept edge until frame end.
- `tx_done`  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- Reset values:
  - `tx_serial`=1, `tx_ready`=0, `tx_busy`=0, `tx_done`=0.
  - State IDLE; bit counter, bit index and shift register all 0.
- `tx_ready` rises on the first `clk` edge after `rst` deasserts.
- Accept: `tx_valid && tx_ready` at a rising edge.
  - On that edge: latch `tx_data` into the shift register, set `tx_ready`=0, set `tx_busy`=1, move to START.
  - `tx_data` and `tx_valid` are don't-care until `tx_ready` returns high.
- State machine:
  - IDLE: `tx_serial`=1; waits for accept.
  - START: `tx_serial`=0 for `CLKS_PER_BIT` cycles; then DATA.
  - DATA: sends 8 bits LSB first, each for `CLKS_PER_BIT` cycles; index 0..7; after bit 7, go to PARITY if the macro is defined, else STOP.
  - PARITY: sends the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles; then STOP.
  - STOP: `tx_serial`=1 for `CLKS_PER_BIT` cycles. In the last cycle: `tx_done`=1 and `tx_busy` still 1. On the next edge: IDLE, `tx_ready`=1, `tx_busy`=0.
  - Any unused encoding returns to IDLE with `tx_serial`=1.
- Bit counter: counts 0..`CLKS_PER_BIT`-1, then wraps to 0 and advances bit/state. Width is `$clog2(CLKS_PER_BIT)`. It never exceeds `CLKS_PER_BIT`-1.
- `tx_serial` is driven from a flop; no combinational path from state to the pin.
- Reset mid-frame: line goes to 1 immediately (asynchronous), the frame is abandoned, no `tx_done`. After release, the frame is not resumed.

## Timing
- Accept at edge E.
  - Start bit occupies cycles E+1 .. E+`CLKS_PER_BIT`.
  - Frame length, first start-bit cycle through `tx_done` cycle inclusive: 10×`CLKS_PER_BIT` (11× with parity).
- `tx_ready` is high the cycle after `tx_done`.
- With `tx_valid` held high, consecutive frames have exactly one extra idle cycle at 1 between the stop bit and the next start bit. Throughput is one byte per 10×`CLKS_PER_BIT`+1 cycles.
- No combinational path from `tx_valid` to `tx_ready`.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state compiled in; frames are 8E1 (11 bits).
  - Undefined: no PARITY state or parity logic; frames are 8N1 (10 bits).
- `uart_rx` must be built with a matching frame format; the macro does not change the port list.

## Structure
- Shared package `uart_pkg` holds:
  - State encodings IDLE/START/DATA/PARITY/STOP, shared with `uart_rx`.
  - `UART_DATA_BITS`=8.
  - Default `UART_CLKS_PER_BIT`=434.
- One natural sub-module, `uart_bit_timer`:
  - Parameterised down-counter with `restart` input and `bit_end` pulse output.
  - Reusable by `uart_rx`.

## Test plan
- `CLKS_PER_BIT`=4, send 0xA5:
  - `tx_serial` = 0,1,0,1,0,0,1,0,1,1 (8N1), each level held exactly 4 cycles.
  - `tx_done` pulses once, 40 cycles after the first start-bit cycle.
- `tx_valid` held high with 0x00 then 0xFF:
  - Two frames, exactly one idle-high cycle between them.
  - `tx_ready` high for exactly 1 cycle between frames.
- Change `tx_data` to 0x3C mid-frame while sending 0x81: transmitted bits remain 0x81; 0x3C is sent only once accepted.
- Assert `rst` during data bit 3:
  - `tx_serial`=1 immediately; `tx_busy`=0; no `tx_done`.
  - After release, 0x55 is transmitted cleanly.
- With `UART_TX_PARITY_EN`:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frame is 44 cycles at `CLKS_PER_BIT`=4.
- Loopback at `CLKS_PER_BIT`=434 into `uart_rx`: bytes 0x00, 0x5A, 0xFF are received identically.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit period and the state
// encodings used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

  // Frame-phase encodings, common to transmitter and receiver.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity over one data byte: 1 when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: a down-counter reloaded by restart, pulsing bit_end in the
// final clk cycle of each bit period. Counts CLKS_PER_BIT-1 down to 0, so the
// count never exceeds CLKS_PER_BIT-1.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on restart or at the end of a period, otherwise count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= CNT_TOP;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign bit_end = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 frames.
// Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready;
// tx_ready is a flop that is high only in IDLE, and tx_data/tx_valid are
// ignored at all other times. tx_state exposes the FSM for debug.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_serial,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic [2:0]                tx_state
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [2:0]                state;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [2:0]                bit_idx;
  logic                      bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      parity_bit;
`endif

  // The timer is held in reload while idle so the start bit gets a full period.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(state == ST_IDLE),
    .bit_end(bit_end)
  );

  // Frame sequencer; tx_serial is registered one cycle ahead of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b0;
      tx_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_serial <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(tx_data);
`endif
            bit_idx   <= '0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            tx_serial <= 1'b0;
            state     <= ST_START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_serial <= shift_reg[0];
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_serial <= parity_bit;
              state     <= ST_PARITY;
`else
              tx_serial <= 1'b1;
              state     <= ST_STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
              tx_serial <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx_serial <= 1'b1;
            state     <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          tx_serial <= 1'b1;
          tx_ready  <= 1'b0;
          tx_busy   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Done marks the last cycle of the stop bit, decoded from registered state.
  assign tx_done  = (state == ST_STOP) && bit_end;
  assign tx_state = state;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4 with hand-computed frames.
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int W   = 1;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] tx_state;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_state (tx_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // frame: bit i = line level during serial bit i (start first), 8N1 form.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.frame[8:0]};
`else
    return {1'b0, v.frame};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", tx_ready, 1);
  endtask

  // Offers d, lets it be accepted, then puts after_d on the bus; returns at
  // the negedge inside the first start-bit cycle.
  task automatic start_frame(input logic [7:0] d, input logic [7:0] after_d, input bit hold);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = after_d;
    if (!hold) tx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Samples every cycle of one frame starting at the current negedge, then
  // checks the idle cycle that follows.
  task automatic check_frame(input logic [10:0] frame, input int tag);
    int done_seen = 0;
    int done_at = -1;
    int busy_bad = 0;
    int ready_bad = 0;
    int bad;
    logic [W-1:0] e;
    for (int i = 0; i < NB; i++) exp_q.push_back(frame[i]);
    check($sformatf("f%0d_start_state", tag), tx_state, ST_START);
    for (int i = 0; i < NB; i++) begin
      e = exp_q.pop_front();
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_serial !== e) bad++;
        if (tx_done === 1'b1) begin
          done_seen++;
          done_at = i * CPB + c;
        end
        if (tx_busy !== 1'b1) busy_bad++;
        if (tx_ready !== 1'b0) ready_bad++;
        if (!(i == NB - 1 && c == CPB - 1)) @(negedge clk);
      end
      check($sformatf("f%0d_bit%0d_bad_cycles", tag, i), bad, 0);
    end
    check($sformatf("f%0d_done_count", tag), done_seen, 1);
    check($sformatf("f%0d_done_cycle", tag), done_at, NB * CPB - 1);
    check($sformatf("f%0d_busy_drop", tag), busy_bad, 0);
    check($sformatf("f%0d_ready_low", tag), ready_bad, 0);
    @(negedge clk);
    check($sformatf("f%0d_post_ready", tag), tx_ready, 1);
    check($sformatf("f%0d_post_busy", tag), tx_busy, 0);
    check($sformatf("f%0d_post_serial", tag), tx_serial, 1);
    check($sformatf("f%0d_post_done", tag), tx_done, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d_cnt;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[4] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[5] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[6] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[7] = '{8'h03, 10'b1000000110, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_state", tx_state, ST_IDLE);
    rst = 1'b0;
    #1;
    check("ready_before_edge", tx_ready, 0);
    @(negedge clk);
    check("ready_after_edge", tx_ready, 1);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      start_frame(vecs[v].data, 8'($urandom_range(0, 255)), 1'b0);
      check_frame(mkframe(vecs[v]), v);
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF
    start_frame(8'h00, 8'hFF, 1'b1);
    check_frame(mkframe(vecs[1]), 100);
    @(negedge clk);
    check("b2b_ready_one_cycle", tx_ready, 0);
    check("b2b_second_start", tx_serial, 0);
    tx_valid = 1'b0;
    check_frame(mkframe(vecs[2]), 101);

    // Data changed mid-frame: 0x81 goes out, 0x3C only once accepted
    start_frame(8'h81, 8'h3C, 1'b0);
    check_frame(mkframe(vecs[3]), 102);
    start_frame(8'h3C, 8'h00, 1'b0);
    check_frame(mkframe(vecs[5]), 103);

    // Reset during data bit 3 of 0xA5 (line low there)
    start_frame(8'hA5, 8'h00, 1'b0);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    check("pre_rst_bit3", tx_serial, 0);
    check("pre_rst_state", tx_state, ST_DATA);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_serial", tx_serial, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_done", tx_done, 0);
    check("mid_rst_state", tx_state, ST_IDLE);
    d_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done === 1'b1) d_cnt++;
    end
    rst = 1'b0;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_serial !== 1'b1) d_cnt++;
    end
    check("rst_no_resume", d_cnt, 0);
    start_frame(8'h55, 8'hAA, 1'b0);
    check_frame(mkframe(vecs[4]), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
